// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types for the register-file writeback initiator.
//   XLEN / REG_AW : data and register-address widths
//   wb_req_t      : one pending register write {rd, data}
//   grant_e       : which source owns the write port this cycle
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_ALU,
    G_LQ,
    G_LD_CT
  } grant_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of wb_req_t used as the load skid buffer.
// Ports:
//   clk_i, regrst_i (async active-low)
//   push, din           : write side (caller guarantees !full)
//   pop, dout           : read side, dout is the current head (show-ahead)
//   full, empty, count  : occupancy status, all derived from registered count
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          regrst_i,
  input  logic          push,
  input  wb_req_t       din,
  input  logic          pop,
  output wb_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge regrst_i) begin
    if (!regrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: write-side initiator for the 32x32 register file.
// Merges ALU results and load results onto one registered write port.
// Ports:
//   clk_i, regrst_i (async active-low)
//   alu_valid_i/alu_ready_o/alu_rd_i/alu_data_i : ALU result handshake
//   ld_valid_i/ld_ready_o/ld_rd_i/ld_data_i     : load result handshake
//   RD_o/WR_o/RWR_EN_o                          : register-file write port
//   lq_count_o                                  : load FIFO occupancy
// Optional build macro RF_BYPASS_EN adds byp_rs1_i/byp_rs2_i,
// byp_hit1_o/byp_hit2_o and byp_data1_o/byp_data2_o so readers can pick up
// the write that lands at the next edge.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk_i,
  input  logic                      regrst_i,
  input  logic                      alu_valid_i,
  output logic                      alu_ready_o,
  input  logic [REG_AW-1:0]         alu_rd_i,
  input  logic [XLEN-1:0]           alu_data_i,
  input  logic                      ld_valid_i,
  output logic                      ld_ready_o,
  input  logic [REG_AW-1:0]         ld_rd_i,
  input  logic [XLEN-1:0]           ld_data_i,
`ifdef RF_BYPASS_EN
  input  logic [REG_AW-1:0]         byp_rs1_i,
  input  logic [REG_AW-1:0]         byp_rs2_i,
  output logic                      byp_hit1_o,
  output logic                      byp_hit2_o,
  output logic [XLEN-1:0]           byp_data1_o,
  output logic [XLEN-1:0]           byp_data2_o,
`endif
  output logic [REG_AW-1:0]         RD_o,
  output logic [XLEN-1:0]           WR_o,
  output logic                      RWR_EN_o,
  output logic [$clog2(LQ_DEPTH):0] lq_count_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  grant_e  grant;
  wb_req_t sel_req;
  wb_req_t fifo_head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_push;
  logic    fifo_pop;
  logic    starve_hold;
  logic [SW-1:0] starve_cnt;

  // Once the ALU has beaten a full FIFO STARVE_MAX times in a row, the
  // head is forced out so loads cannot be stalled indefinitely.
  assign starve_hold = fifo_full && (starve_cnt == STARVE_TOP);
  assign alu_ready_o = !starve_hold;
  assign ld_ready_o  = !fifo_full;

  always_comb begin
    grant = G_NONE;
    if (starve_hold)      grant = G_LQ;
    else if (alu_valid_i) grant = G_ALU;
    else if (!fifo_empty) grant = G_LQ;
    else if (ld_valid_i)  grant = G_LD_CT;
  end

  // A cut-through load goes straight to the port and must not also be queued.
  assign fifo_push = ld_valid_i && ld_ready_o && (grant != G_LD_CT);
  assign fifo_pop  = (grant == G_LQ);

  always_comb begin
    sel_req = '0;
    case (grant)
      G_ALU:   sel_req = '{rd: alu_rd_i, data: alu_data_i};
      G_LQ:    sel_req = fifo_head;
      G_LD_CT: sel_req = '{rd: ld_rd_i, data: ld_data_i};
      default: sel_req = '0;
    endcase
  end

  rf_wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk_i    (clk_i),
    .regrst_i (regrst_i),
    .push     (fifo_push),
    .din      ('{rd: ld_rd_i, data: ld_data_i}),
    .pop      (fifo_pop),
    .dout     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (lq_count_o)
  );

  always_ff @(posedge clk_i or negedge regrst_i) begin
    if (!regrst_i) begin
      starve_cnt <= '0;
    end else if (fifo_pop || !fifo_full) begin
      starve_cnt <= '0;
    end else if ((grant == G_ALU) && (starve_cnt != STARVE_TOP)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // x0 writes are consumed (address/data still update) but never enabled.
  always_ff @(posedge clk_i or negedge regrst_i) begin
    if (!regrst_i) begin
      RD_o     <= '0;
      WR_o     <= '0;
      RWR_EN_o <= 1'b0;
    end else if (grant != G_NONE) begin
      RD_o     <= sel_req.rd;
      WR_o     <= sel_req.data;
      RWR_EN_o <= (sel_req.rd != '0);
    end else begin
      RWR_EN_o <= 1'b0;
    end
  end

`ifdef RF_BYPASS_EN
  assign byp_hit1_o  = RWR_EN_o && (RD_o == byp_rs1_i) && (byp_rs1_i != '0);
  assign byp_hit2_o  = RWR_EN_o && (RD_o == byp_rs2_i) && (byp_rs2_i != '0);
  assign byp_data1_o = WR_o;
  assign byp_data2_o = WR_o;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  logic        clk_i = 1'b0;
  logic        regrst_i = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i = '0;
  logic [31:0] ld_data_i = '0;
  logic [4:0]  RD_o;
  logic [31:0] WR_o;
  logic        RWR_EN_o;
  logic [1:0]  lq_count_o;
`ifdef RF_BYPASS_EN
  logic [4:0]  byp_rs1_i = '0;
  logic [4:0]  byp_rs2_i = '0;
  logic        byp_hit1_o;
  logic        byp_hit2_o;
  logic [31:0] byp_data1_o;
  logic [31:0] byp_data2_o;
`endif

  rf_writeback #(.LQ_DEPTH(2), .STARVE_MAX(3)) dut (
    .clk_i       (clk_i),
    .regrst_i    (regrst_i),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_rd_i     (ld_rd_i),
    .ld_data_i   (ld_data_i),
`ifdef RF_BYPASS_EN
    .byp_rs1_i   (byp_rs1_i),
    .byp_rs2_i   (byp_rs2_i),
    .byp_hit1_o  (byp_hit1_o),
    .byp_hit2_o  (byp_hit2_o),
    .byp_data1_o (byp_data1_o),
    .byp_data2_o (byp_data2_o),
`endif
    .RD_o        (RD_o),
    .WR_o        (WR_o),
    .RWR_EN_o    (RWR_EN_o),
    .lq_count_o  (lq_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        exp_alu_ready;
    logic        exp_ld_ready;
    logic [1:0]  exp_count;
    logic        exp_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t vt[$];
  wr_t  sbq[$];
  int   n_applied = 0;
  int   n_miscompare = 0;

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                              logic lv, logic [4:0] lr, logic [31:0] ldd,
                              logic ear, logic elr, logic [1:0] ec,
                              logic ew, logic [4:0] erd, logic [31:0] ed);
    vec_t v;
    v.alu_v = av; v.alu_rd = ar; v.alu_data = ad;
    v.ld_v = lv; v.ld_rd = lr; v.ld_data = ldd;
    v.exp_alu_ready = ear; v.exp_ld_ready = elr; v.exp_count = ec;
    v.exp_wen = ew; v.exp_rd = erd; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input vec_t v, input int idx);
    wr_t e;
    wr_t got;
    alu_valid_i = v.alu_v; alu_rd_i = v.alu_rd; alu_data_i = v.alu_data;
    ld_valid_i  = v.ld_v;  ld_rd_i  = v.ld_rd;  ld_data_i  = v.ld_data;
    #1;
    chk($sformatf("v%0d alu_ready", idx), 64'(alu_ready_o), 64'(v.exp_alu_ready));
    chk($sformatf("v%0d ld_ready", idx),  64'(ld_ready_o),  64'(v.exp_ld_ready));
    chk($sformatf("v%0d lq_count", idx),  64'(lq_count_o),  64'(v.exp_count));
    e.wen = v.exp_wen; e.rd = v.exp_rd; e.data = v.exp_data;
    sbq.push_back(e);
    @(posedge clk_i);
    #1;
    got = sbq.pop_front();
    chk($sformatf("v%0d wen", idx), 64'(RWR_EN_o), 64'(got.wen));
    if (got.wen) begin
      chk($sformatf("v%0d rd", idx),   64'(RD_o), 64'(got.rd));
      chk($sformatf("v%0d data", idx), 64'(WR_o), 64'(got.data));
    end
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    ld_valid_i = 1'b0;  ld_rd_i = '0;  ld_data_i = '0;
  endtask

  initial begin
    //        alu_v rd     data          ld_v rd    data          ar   lr   cnt  wen  rd     data
    // single ALU write, then idle
    vt.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 1, 2'd0, 1, 5'd5,  32'hDEADBEEF));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd0, 0, 5'd0,  32'h0));
    // ALU write to x0 is consumed but suppressed
    vt.push_back(mk(1, 5'd0,  32'h1234,     0, 5'd0, 32'h0,        1, 1, 2'd0, 0, 5'd0,  32'h0));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd0, 0, 5'd0,  32'h0));
    // load cut-through with empty FIFO and idle ALU
    vt.push_back(mk(0, 5'd0,  32'h0,        1, 5'd7, 32'hA5A5A5A5, 1, 1, 2'd0, 1, 5'd7,  32'hA5A5A5A5));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd0, 0, 5'd0,  32'h0));
    // starvation: ALU valid every cycle, loads rd=1,2 queue up
    vt.push_back(mk(1, 5'd10, 32'h100,      1, 5'd1, 32'h11,       1, 1, 2'd0, 1, 5'd10, 32'h100));
    vt.push_back(mk(1, 5'd11, 32'h101,      1, 5'd2, 32'h22,       1, 1, 2'd1, 1, 5'd11, 32'h101));
    vt.push_back(mk(1, 5'd12, 32'h102,      1, 5'd3, 32'h33,       1, 0, 2'd2, 1, 5'd12, 32'h102));
    vt.push_back(mk(1, 5'd13, 32'h103,      1, 5'd3, 32'h33,       1, 0, 2'd2, 1, 5'd13, 32'h103));
    vt.push_back(mk(1, 5'd14, 32'h104,      1, 5'd3, 32'h33,       1, 0, 2'd2, 1, 5'd14, 32'h104));
    vt.push_back(mk(1, 5'd15, 32'h105,      1, 5'd3, 32'h33,       0, 0, 2'd2, 1, 5'd1,  32'h11));
    vt.push_back(mk(1, 5'd15, 32'h105,      0, 5'd0, 32'h0,        1, 1, 2'd1, 1, 5'd15, 32'h105));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd1, 1, 5'd2,  32'h22));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd0, 0, 5'd0,  32'h0));
    // push and pop in the same cycle at count=1
    vt.push_back(mk(1, 5'd20, 32'h200,      1, 5'd3, 32'h33,       1, 1, 2'd0, 1, 5'd20, 32'h200));
    vt.push_back(mk(0, 5'd0,  32'h0,        1, 5'd4, 32'h44,       1, 1, 2'd1, 1, 5'd3,  32'h33));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd1, 1, 5'd4,  32'h44));
    vt.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 2'd0, 0, 5'd0,  32'h0));
    // fill FIFO to 2 ahead of a mid-burst reset
    vt.push_back(mk(1, 5'd21, 32'h300,      1, 5'd5, 32'h55,       1, 1, 2'd0, 1, 5'd21, 32'h300));
    vt.push_back(mk(1, 5'd22, 32'h301,      1, 5'd6, 32'h66,       1, 1, 2'd1, 1, 5'd22, 32'h301));

    // reset state
    #12;
    chk("rst RWR_EN", 64'(RWR_EN_o),   64'd0);
    chk("rst RD",     64'(RD_o),       64'd0);
    chk("rst WR",     64'(WR_o),       64'd0);
    chk("rst count",  64'(lq_count_o), 64'd0);
    #10 regrst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < vt.size(); i++) step(vt[i], i);

    // mid-burst reset with two loads buffered
    idle_inputs();
    #1;
    chk("pre-rst count",  64'(lq_count_o), 64'd2);
    chk("pre-rst RWR_EN", 64'(RWR_EN_o),   64'd1);
    #1 regrst_i = 1'b0;
    #1;
    chk("mid-rst RWR_EN", 64'(RWR_EN_o),   64'd0);
    chk("mid-rst RD",     64'(RD_o),       64'd0);
    chk("mid-rst WR",     64'(WR_o),       64'd0);
    chk("mid-rst count",  64'(lq_count_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #3 regrst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("post-rst%0d RWR_EN", c), 64'(RWR_EN_o),   64'd0);
      chk($sformatf("post-rst%0d count", c),  64'(lq_count_o), 64'd0);
    end
    // fresh traffic after reset still works
    step(mk(0, 5'd0, 32'h0, 1, 5'd9, 32'hCAFEF00D, 1, 1, 2'd0, 1, 5'd9, 32'hCAFEF00D), 99);
    idle_inputs();
    step(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 2'd0, 0, 5'd0, 32'h0), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side initiator for the core's 32x32 register file. Drives the file's write port: RD, WR and RWR_EN.
- Merges two result sources onto that single port:
  - the ALU, through a valid/ready handshake;
  - the load unit, through a valid/ready handshake and a small skid FIFO.
- Arbitration is starvation-bounded. Output write commands are registered.

Parameters:
- XLEN, 32, data width of a register write.
- REG_AW, 5, register address width.
- LQ_DEPTH, 2, load FIFO depth (power of 2, ≥2).
- STARVE_MAX, 3, consecutive lost grants with FIFO full before the ALU is held off.

Ports:
- clk_i  in  1  core clock, all state on rising edge.
- regrst_i  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU result accepted this cycle (combinational).
- alu_rd_i  in  REG_AW  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- ld_valid_i  in  1  load result valid.
- ld_ready_o  out  1  load result accepted; equals !fifo_full.
- ld_rd_i  in  REG_AW  load destination register.
- ld_data_i  in  XLEN  load data.
- RD_o  out  REG_AW  register-file write address.
- WR_o  out  XLEN  register-file write data.
- RWR_EN_o  out  1  register-file write enable.
- lq_count_o  out  $clog2(LQ_DEPTH)+1  FIFO occupancy, for debug and perf.

Behaviour:
- Reset (regrst_i low, asynchronous):
  - RD_o=0, WR_o=0, RWR_EN_o=0, lq_count_o=0.
  - FIFO pointers and starvation counter cleared.
  - Reset mid-operation drops all buffered loads; no write is issued after release until new input arrives.
- Per-cycle grant, evaluated combinationally. Exactly one source or none:
  1. starve_hold = (fifo_full && starve_cnt==STARVE_MAX). If set, the FIFO head is granted and alu_ready_o=0.
  2. Else, if alu_valid_i is high, the ALU is granted and alu_ready_o=1.
  3. Else, if the FIFO is non-empty, the FIFO head is granted.
  4. Else, if ld_valid_i is high and the FIFO is empty, the load is cut through directly and is not pushed.
  5. Else, no grant.
- alu_ready_o = !starve_hold. It is independent of alu_valid_i.
- Load push: ld_valid_i && ld_ready_o && !cut_through. Simultaneous push and pop of the head is legal and leaves the count unchanged.
- ld_ready_o depends only on the registered count. A pop in the same cycle does not raise it.
- starve_cnt:
  - increments when fifo_full and the ALU wins;
  - saturates at STARVE_MAX;
  - clears on any FIFO pop or when the FIFO is not full.
- Output register: on a grant, next-cycle RD_o/WR_o take the granted rd/data. Latency is exactly 1 cycle from acceptance to RWR_EN_o.
- RWR_EN_o = grant && rd!=0. A write to x0 is consumed but suppressed. With no grant, RWR_EN_o=0 and RD_o/WR_o hold their values.
- Ordering: FIFO order is preserved among loads. Ordering between the ALU and load sources is not guaranteed; same-rd hazards are resolved upstream.

Optional Feature:
- RF_BYPASS_EN defined adds six ports:
  - byp_rs1_i and byp_rs2_i (in, REG_AW);
  - byp_hit1_o and byp_hit2_o (out, 1);
  - byp_data1_o and byp_data2_o (out, XLEN).
- byp_hitN_o = RWR_EN_o && RD_o==byp_rsN_i && byp_rsN_i!=0, combinational. byp_dataN_o = WR_o.
- This lets readers see the write landing at the next edge.
- RF_BYPASS_EN undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package rf_wb_pkg holds:
  - XLEN and REG_AW localparams;
  - typedef wb_req_t struct {rd, data};
  - enum grant_e {G_NONE, G_ALU, G_LQ, G_LD_CT}.
- Sub-module rf_wb_fifo: a parameterized synchronous FIFO of wb_req_t with push, pop, full, empty and count, reset by regrst_i.

Test Plan:
- Reset then single ALU result (rd=5, data=0xDEADBEEF) → next cycle RWR_EN_o=1, RD_o=5, WR_o=0xDEADBEEF. The cycle after, RWR_EN_o=0.
- ALU result to rd=0 (data=0x1234) → alu_ready_o=1 and RWR_EN_o stays 0.
- Load while ALU idle and FIFO empty (rd=7, data=0xA5A5A5A5) → cut through, lq_count_o stays 0, write appears after 1 cycle.
- ALU valid every cycle while loads rd=1,2 arrive:
  - FIFO fills to 2 and ld_ready_o goes 0;
  - after 3 lost grants alu_ready_o drops for one cycle;
  - rd=1 is written, then the ALU resumes.
- Push and pop in the same cycle with count=1 → count stays 1 and the loads are written in arrival order.
- Assert regrst_i low mid-burst with count=2 → outputs 0 immediately; after release, no stale writes; lq_count_o=0.
